// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller using an external dual-port SRAM as storage,
// with a 2-entry output buffer that hides the SRAM's 1-cycle read latency.
module sram_fifo_ctrl #(
  parameter int unsigned BW    = 8,
  parameter int unsigned NDATA = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_src_valid,
  output logic                     o_src_ready,
  input  logic [BW-1:0]            i_src_data,
  output logic                     o_dst_valid,
  input  logic                     i_dst_ready,
  output logic [BW-1:0]            o_dst_data,
  output logic                     o_sram_we,
  output logic                     o_sram_re,
  output logic [$clog2(NDATA)-1:0] o_sram_waddr,
  output logic [BW-1:0]            o_sram_wdata,
  output logic [$clog2(NDATA)-1:0] o_sram_raddr,
  input  logic [BW-1:0]            i_sram_rdata
);

  localparam int unsigned AW = $clog2(NDATA);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] sram_cnt;
  logic          inflight_q;
  logic [1:0]    occ_q, occ_d;
  logic [BW-1:0] ob0_q, ob0_d;
  logic [BW-1:0] ob1_q, ob1_d;
  logic          push, pop, rd_issue, sram_full, sram_empty, buf_room;

  // Pointer MSB is a wrap bit, so the modulo difference spans 0..NDATA.
  assign sram_cnt   = wptr_q - rptr_q;
  assign sram_full  = (sram_cnt == PW'(NDATA));
  assign sram_empty = (sram_cnt == '0);

  assign o_src_ready = i_rst_n & ~sram_full;
  assign push        = i_src_valid & o_src_ready;
  assign o_dst_valid = (occ_q != 2'd0);
  assign pop         = o_dst_valid & i_dst_ready;

  // A read is only issued when a buffer slot is guaranteed at capture time.
  assign buf_room = (3'(occ_q) + 3'(inflight_q)) < 3'd2;
  assign rd_issue = i_rst_n & ~sram_empty & (buf_room | pop);

  assign o_sram_we    = push;
  assign o_sram_re    = rd_issue;
  assign o_sram_waddr = i_rst_n ? wptr_q[AW-1:0] : '0;
  assign o_sram_raddr = i_rst_n ? rptr_q[AW-1:0] : '0;
  assign o_sram_wdata = i_src_data;
  assign o_dst_data   = ob0_q;

  // Next-state: pointers, occupancy and output-buffer slot shuffling.
  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(rd_issue);
    occ_d  = 2'(3'(occ_q) + 3'(inflight_q) - 3'(pop));
    ob0_d  = ob0_q;
    ob1_d  = ob1_q;
    if (pop && (occ_q == 2'd2)) begin
      ob0_d = ob1_q;
    end
    if (inflight_q) begin
      if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
        ob0_d = i_sram_rdata;
      end else begin
        ob1_d = i_sram_rdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= rd_issue;
      occ_q      <= occ_d;
    end
  end

  // Data slots carry no reset; they are qualified by occ_q.
  always_ff @(posedge i_clk) begin
    ob0_q <= ob0_d;
    ob1_q <= ob1_d;
  end

endmodule
